icache_fetch_assoc: RTL and testbench

//  Next-generation instruction fetch stage with a parametrised N-way set-associative instruction cache.

---
 rtl/icache_fetch_assoc.sv | 228 ++++++++++++++++++++++
 tb/tb_icache_fetch_assoc.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_assoc.sv
// Instruction fetch stage with an N-way set-associative instruction cache.
// Lookup is single-cycle and combinational on the current fetch vaddr.
// On a miss, the stage requests the line through its own refill handshake.
// Lines carry the privilege mode and MMU state they were filled under as part of the tag.
module icache_fetch_assoc #(
    parameter int              XLEN        = 64,
    parameter int              VLEN        = 39,
    parameter logic [XLEN-1:0] RESET_VADDR = '0,
    parameter int              WAYS        = 2,
    parameter int              SET_LOG2    = 7,
    parameter int              LINE_WORDS  = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       stall,
    input  logic                       mmu_enabled,
    input  logic [1:0]                 current_mode,
    input  logic                       current_sum,
    input  logic                       redirect,
    input  logic [XLEN-1:1]            redirect_vaddr,
    input  logic [XLEN-1:1]            predicted_vaddr,
    output logic [XLEN-1:1]            instruction_vaddr,
    output logic [31:2]                instruction_word,
    output logic                       instruction_valid,
    output logic                       instruction_addr_misaligned,
    output logic                       refill_req,
    output logic [VLEN-1:$clog2(LINE_WORDS)+2] refill_addr,
    input  logic                       refill_valid,
    input  logic [LINE_WORDS*32-1:0]   refill_data,
    input  logic                       cache_invalidate,
    input  logic                       selective_invalidate,
    input  logic                       selective_invalidate_vaddr
);

    localparam int LOB   = $clog2(LINE_WORDS) + 2;
    localparam int SETS  = 1 << SET_LOG2;
    localparam int TAG_W = VLEN - LOB - SET_LOG2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WORD_W = LOB - 2;

    // Privilege mode encodings relevant to the SUM rule
    localparam logic [1:0] MODE_U = 2'd0;
    localparam logic [1:0] MODE_S = 2'd1;

    typedef enum logic {
        S_IDLE,
        S_REFILL
    } state_t;

    state_t             r_state;
    logic               r_refill_req;
    logic [VLEN-1:LOB]  r_refill_addr;
    logic               r_stale;
    logic [XLEN-1:1]    r_vaddr;
    logic [WAY_W-1:0]   r_rr [SETS];

    logic [SET_LOG2-1:0] w_index;
    logic [WORD_W-1:0]   w_word;
    logic [TAG_W-1:0]    w_vtag;
    logic                w_canon;
    logic [SET_LOG2-1:0] w_fill_index;
    logic [TAG_W-1:0]    w_fill_tag;
    logic [WAYS-1:0]     w_way_hit;
    logic [29:0]         w_way_word [WAYS];
    logic [WAYS-1:0]     w_fill_valid;
    logic [29:0]         w_fill_words [LINE_WORDS];
    logic [WAY_W-1:0]    w_victim;
    logic [29:0]         w_hit_word;
    logic                w_hit;
    logic                w_instr_valid;
    logic                w_inv;
    logic                w_write;
    logic                w_launch;

    assign w_index = r_vaddr[LOB+SET_LOG2-1:LOB];
    assign w_word  = r_vaddr[LOB-1:2];
    assign w_vtag  = r_vaddr[VLEN-1:LOB+SET_LOG2];
    // Only canonical (sign-extended VLEN) vaddrs can match a stored tag
    assign w_canon = (&r_vaddr[XLEN-1:VLEN-1]) || (~|r_vaddr[XLEN-1:VLEN-1]);

    assign w_fill_index = r_refill_addr[LOB+SET_LOG2-1:LOB];
    assign w_fill_tag   = r_refill_addr[VLEN-1:LOB+SET_LOG2];

    assign w_hit         = |w_way_hit;
    assign w_instr_valid = (r_state == S_IDLE) && (r_vaddr[1] || w_hit);
    assign w_inv         = cache_invalidate && !stall;
    // An invalidate in the same cycle wins over the arriving line
    assign w_write       = (r_state == S_REFILL) && refill_valid && !r_stale && !w_inv;
    assign w_launch      = (r_state == S_IDLE) && !stall && !w_instr_valid && !redirect && !cache_invalidate;

    // Compressed (non-32-bit) encodings are stored as an all-ones illegal word
    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_conv
            assign w_fill_words[gi] = (refill_data[gi*32 +: 2] == 2'b11) ?
                                      refill_data[gi*32+2 +: 30] : 30'h3FFF_FFFF;
        end
    endgenerate

    // Each way owns its valid bits and storage; lookup results are exported per way
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            logic [SETS-1:0]  r_valid;
            logic [TAG_W-1:0] r_tag  [SETS];
            logic [1:0]       r_mode [SETS];
            logic             r_mmu  [SETS];
            logic [29:0]      r_data [SETS][LINE_WORDS];
            logic             w_mode_ok;
            logic             w_sel;

            assign w_sel = w_write && (w_victim == WAY_W'(gi));

            // Valid bits: reset/invalidate clear them, a fill into this way sets one
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    r_valid <= '0;
                end else if (w_inv) begin
                    for (int s = 0; s < SETS; s++) begin
                        if (!selective_invalidate ||
                            (r_tag[s][TAG_W-1] == selective_invalidate_vaddr)) begin
                            r_valid[s] <= 1'b0;
                        end
                    end
                end else if (w_sel) begin
                    r_valid[w_fill_index] <= 1'b1;
                end
            end

            // Tag and line storage, written under the mode/MMU state current at fill
            always_ff @(posedge clock) begin
                if (w_sel) begin
                    r_tag[w_fill_index]  <= w_fill_tag;
                    r_mode[w_fill_index] <= current_mode;
                    r_mmu[w_fill_index]  <= mmu_enabled;
                    for (int k = 0; k < LINE_WORDS; k++) begin
                        r_data[w_fill_index][k] <= w_fill_words[k];
                    end
                end
            end

            assign w_mode_ok = (r_mode[w_index] == current_mode) ||
                               ((current_mode == MODE_S) && current_sum && (r_mode[w_index] == MODE_U));
            assign w_way_hit[gi]    = r_valid[w_index] && w_canon && (r_tag[w_index] == w_vtag) &&
                                      (r_mmu[w_index] == mmu_enabled) && w_mode_ok;
            assign w_way_word[gi]   = r_data[w_index][w_word];
            assign w_fill_valid[gi] = r_valid[w_fill_index];
        end
    endgenerate

    // Hit word selection: lowest-indexed hitting way wins
    always_comb begin
        w_hit_word = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (w_way_hit[i]) begin
                w_hit_word = w_way_word[i];
            end
        end
    end

    // Victim selection: lowest invalid way, otherwise the set's round-robin pointer
    always_comb begin
        w_victim = r_rr[w_fill_index];
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!w_fill_valid[i]) begin
                w_victim = WAY_W'(i);
            end
        end
    end

    // Fetch vaddr, refill FSM, stale tracking and replacement pointers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_refill_req  <= 1'b0;
            r_refill_addr <= '0;
            r_stale       <= 1'b0;
            r_vaddr       <= RESET_VADDR[XLEN-1:1];
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
            end
        end else begin
            if (!stall) begin
                if (redirect) begin
                    r_vaddr <= redirect_vaddr;
                end else if (w_instr_valid) begin
                    r_vaddr <= predicted_vaddr;
                end
            end

            // Pointer only moves when a full set has to evict
            if (w_write && (&w_fill_valid)) begin
                r_rr[w_fill_index] <= (r_rr[w_fill_index] == WAY_W'(WAYS - 1)) ?
                                      '0 : r_rr[w_fill_index] + WAY_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state       <= S_REFILL;
                        r_refill_req  <= 1'b1;
                        r_refill_addr <= r_vaddr[VLEN-1:LOB];
                        r_stale       <= 1'b0;
                    end
                end
                S_REFILL: begin
                    if (refill_valid) begin
                        r_state      <= S_IDLE;
                        r_refill_req <= 1'b0;
                        r_stale      <= 1'b0;
                    end else if (w_inv) begin
                        r_stale <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign instruction_vaddr           = r_vaddr;
    assign instruction_word            = w_hit_word;
    assign instruction_valid           = w_instr_valid;
    assign instruction_addr_misaligned = r_vaddr[1];
    assign refill_req                  = r_refill_req;
    assign refill_addr                 = r_refill_addr;

endmodule

// File: tb/tb_icache_fetch_assoc.sv
// Bench for icache_fetch_assoc: directed scenarios plus a randomized run,
// checked against a set/way reference model of the cache kept here.
module tb_icache_fetch_assoc;

    localparam int NSETS = 128;
    localparam int NW    = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          stall;
    logic          mmu_enabled;
    logic [1:0]    current_mode;
    logic          current_sum;
    logic          redirect;
    logic [63:1]   redirect_vaddr;
    logic [63:1]   predicted_vaddr;
    logic [63:1]   instruction_vaddr;
    logic [31:2]   instruction_word;
    logic          instruction_valid;
    logic          instruction_addr_misaligned;
    logic          refill_req;
    logic [38:5]   refill_addr;
    logic          refill_valid;
    logic [255:0]  refill_data;
    logic          cache_invalidate;
    logic          selective_invalidate;
    logic          selective_invalidate_vaddr;

    int n_checks = 0;
    int n_fail   = 0;

    icache_fetch_assoc #(
        .XLEN(64), .VLEN(39), .RESET_VADDR(64'h0), .WAYS(2), .SET_LOG2(7), .LINE_WORDS(8)
    ) dut (
        .clock                       (clock),
        .reset_n                     (reset_n),
        .stall                       (stall),
        .mmu_enabled                 (mmu_enabled),
        .current_mode                (current_mode),
        .current_sum                 (current_sum),
        .redirect                    (redirect),
        .redirect_vaddr              (redirect_vaddr),
        .predicted_vaddr             (predicted_vaddr),
        .instruction_vaddr           (instruction_vaddr),
        .instruction_word            (instruction_word),
        .instruction_valid           (instruction_valid),
        .instruction_addr_misaligned (instruction_addr_misaligned),
        .refill_req                  (refill_req),
        .refill_addr                 (refill_addr),
        .refill_valid                (refill_valid),
        .refill_data                 (refill_data),
        .cache_invalidate            (cache_invalidate),
        .selective_invalidate        (selective_invalidate),
        .selective_invalidate_vaddr  (selective_invalidate_vaddr)
    );

    always #5 clock = ~clock;

    // Reference model: per set, per way, the line address and fill context
    bit          m_valid [NSETS][NW];
    logic [51:0] m_line  [NSETS][NW];
    bit          m_top   [NSETS][NW];
    logic [1:0]  m_mode  [NSETS][NW];
    bit          m_mmu   [NSETS][NW];
    bit [31:0]   m_data  [NSETS][NW][8];
    int          m_rr    [NSETS];
    bit [31:0]   fill_words [8];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit [29:0] m_conv(bit [31:0] w);
        return (w[1:0] == 2'b11) ? w[31:2] : 30'h3FFF_FFFF;
    endfunction

    function automatic int m_find(logic [63:0] a);
        int s = int'(a[11:5]);
        for (int w = 0; w < NW; w++) begin
            if (m_valid[s][w] && m_line[s][w] == a[63:12] && m_mmu[s][w] == mmu_enabled &&
                (m_mode[s][w] == current_mode ||
                 (current_mode == 2'd1 && current_sum && m_mode[s][w] == 2'd0)))
                return w;
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int s = 0; s < NSETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    task automatic m_install(input logic [63:0] a);
        int s = int'(a[11:5]);
        int v = -1;
        for (int w = 0; w < NW; w++) if (!m_valid[s][w] && v < 0) v = w;
        if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % NW;
        end
        m_valid[s][v] = 1'b1;
        m_line[s][v]  = a[63:12];
        m_top[s][v]   = a[38];
        m_mode[s][v]  = current_mode;
        m_mmu[s][v]   = mmu_enabled;
        for (int k = 0; k < 8; k++) m_data[s][v][k] = fill_words[k];
    endtask

    task automatic m_invalidate(input bit sel, input bit v);
        for (int s = 0; s < NSETS; s++)
            for (int w = 0; w < NW; w++)
                if (!sel || m_top[s][w] == v) m_valid[s][w] = 1'b0;
    endtask

    task automatic rand_words();
        for (int k = 0; k < 8; k++) fill_words[k] = $urandom();
    endtask

    function automatic logic [255:0] pack_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = fill_words[k];
        return l;
    endfunction

    // Invalidate pulse; redirect held so no refill launches during it
    task automatic inv_pulse(input bit sel, input bit v);
        cache_invalidate = 1'b1;
        selective_invalidate = sel;
        selective_invalidate_vaddr = v;
        redirect = 1'b1;
        tick();
        cache_invalidate = 1'b0;
        selective_invalidate = 1'b0;
        m_invalidate(sel, v);
        $display("invalidate sel=%0b top=%0b", sel, v);
    endtask

    // Redirect to a, check lookup; on expected miss, service the refill and recheck.
    // exp_hit: -1 use model, 0 must miss, 1 must hit
    task automatic do_fetch(input logic [63:0] a, input int exp_hit);
        int w;
        int wi;
        bit exp_v;
        redirect = 1'b1;
        redirect_vaddr = a[63:1];
        predicted_vaddr = a[63:1];
        tick();
        redirect = 1'b0;
        #1;
        wi = int'(a[4:2]);
        w = m_find(a);
        exp_v = a[1] ? 1'b1 : ((exp_hit >= 0) ? exp_hit[0] : (w >= 0));
        n_checks++;
        if (instruction_vaddr !== a[63:1]) begin
            n_fail++;
            $display("FAIL vaddr: got %h expected %h", instruction_vaddr, a[63:1]);
        end
        n_checks++;
        if (instruction_valid !== exp_v) begin
            n_fail++;
            $display("FAIL lookup %h: valid got %b expected %b", a, instruction_valid, exp_v);
        end
        n_checks++;
        if (instruction_addr_misaligned !== a[1]) begin
            n_fail++;
            $display("FAIL misaligned %h: got %b expected %b", a, instruction_addr_misaligned, a[1]);
        end
        if (!a[1] && exp_v && w >= 0) begin
            n_checks++;
            if (instruction_word !== m_conv(m_data[int'(a[11:5])][w][wi])) begin
                n_fail++;
                $display("FAIL hit word %h: got %h expected %h", a, instruction_word,
                         m_conv(m_data[int'(a[11:5])][w][wi]));
            end
        end
        if (!exp_v) begin
            tick();
            n_checks++;
            if (refill_req !== 1'b1 || refill_addr !== a[38:5]) begin
                n_fail++;
                $display("FAIL refill req %h: req=%b addr=%h expected req=1 addr=%h", a, refill_req, refill_addr, a[38:5]);
            end
            repeat ($urandom_range(0, 2)) tick();
            refill_valid = 1'b1;
            refill_data = pack_line();
            m_install(a);
            tick();
            refill_valid = 1'b0;
            #1;
            n_checks++;
            if (refill_req !== 1'b0) begin
                n_fail++;
                $display("FAIL refill drop %h: req got %b expected 0", a, refill_req);
            end
            n_checks++;
            if (instruction_valid !== 1'b1 || instruction_word !== m_conv(fill_words[wi])) begin
                n_fail++;
                $display("FAIL after fill %h: valid=%b word=%h expected valid=1 word=%h", a, instruction_valid, instruction_word, m_conv(fill_words[wi]));
            end
        end
        $display("fetch %h mode=%0d sum=%0b mmu=%0b miss=%0b word=%h", a, current_mode, current_sum, mmu_enabled, !exp_v, instruction_word);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stall = 1'b0; mmu_enabled = 1'b0; current_mode = 2'd3; current_sum = 1'b0;
        redirect = 1'b0; redirect_vaddr = '0; predicted_vaddr = '0; refill_valid = 1'b0;
        refill_data = '0; cache_invalidate = 1'b0; selective_invalidate = 1'b0;
        selective_invalidate_vaddr = 1'b0;
        repeat (3) tick();
        m_reset();
        n_checks++;
        if (instruction_vaddr !== 63'h0 || refill_req !== 1'b0 || instruction_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: vaddr=%h req=%b valid=%b expected 0/0/0", instruction_vaddr, refill_req, instruction_valid);
        end
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (refill_req !== 1'b1 || refill_addr !== 34'h0) begin
            n_fail++;
            $display("FAIL first refill: req=%b addr=%h expected 1/0", refill_req, refill_addr);
        end
        rand_words();
        fill_words[0] = 32'h0000_0013;
        refill_valid = 1'b1;
        refill_data = pack_line();
        m_install(64'h0);
        tick();
        refill_valid = 1'b0;
        n_checks++;
        if (instruction_valid !== 1'b1 || instruction_word !== 30'h4) begin
            n_fail++;
            $display("FAIL first fill: valid=%b word=%h expected 1/00000004", instruction_valid, instruction_word);
        end
        $display("reset and first fill word=%h", instruction_word);
    endtask

    task automatic test_compressed();
        rand_words();
        fill_words[1] = 32'h0000_0001;
        do_fetch(64'h2000, 0);
        do_fetch(64'h2004, 1);
        n_checks++;
        if (instruction_word !== 30'h3FFF_FFFF) begin
            n_fail++;
            $display("FAIL compressed: got %h expected 3fffffff", instruction_word);
        end
    endtask

    task automatic test_rr_evict();
        rand_words(); do_fetch(64'h10A0, 0);
        rand_words(); do_fetch(64'h20A0, 0);
        rand_words(); do_fetch(64'h30A0, 0);
        do_fetch(64'h20A0, 1);
        do_fetch(64'h30A0, 1);
        rand_words(); do_fetch(64'h10A0, 0);
        rand_words(); do_fetch(64'h20A0, 0);
    endtask

    task automatic test_selective();
        rand_words(); do_fetch(64'hFFFF_FFC0_0000_0040, 0);
        rand_words(); do_fetch(64'h0000_0000_0000_0040, 0);
        inv_pulse(1'b1, 1'b1);
        do_fetch(64'h0000_0000_0000_0040, 1);
        rand_words(); do_fetch(64'hFFFF_FFC0_0000_0044, 0);
    endtask

    task automatic test_inv_refill();
        logic [63:0] a = 64'h7060;
        redirect = 1'b1; redirect_vaddr = a[63:1]; predicted_vaddr = a[63:1];
        tick();
        redirect = 1'b0;
        tick();
        n_checks++;
        if (refill_req !== 1'b1) begin
            n_fail++;
            $display("FAIL inv refill start: req got %b expected 1", refill_req);
        end
        cache_invalidate = 1'b1;
        tick();
        cache_invalidate = 1'b0;
        m_invalidate(1'b0, 1'b0);
        rand_words();
        refill_valid = 1'b1; refill_data = pack_line();
        tick();
        refill_valid = 1'b0;
        n_checks++;
        if (refill_req !== 1'b0 || instruction_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stale drop: req=%b valid=%b expected 0/0", refill_req, instruction_valid);
        end
        tick();
        n_checks++;
        if (refill_req !== 1'b1) begin
            n_fail++;
            $display("FAIL refetch after stale: req got %b expected 1", refill_req);
        end
        // invalidate coinciding with the returning line
        cache_invalidate = 1'b1; refill_valid = 1'b1;
        tick();
        cache_invalidate = 1'b0; refill_valid = 1'b0;
        m_invalidate(1'b0, 1'b0);
        n_checks++;
        if (instruction_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL same-cycle invalidate: valid got %b expected 0", instruction_valid);
        end
        tick();
        rand_words();
        refill_valid = 1'b1; refill_data = pack_line();
        m_install(a);
        tick();
        refill_valid = 1'b0;
        n_checks++;
        if (instruction_valid !== 1'b1 || instruction_word !== m_conv(fill_words[0])) begin
            n_fail++;
            $display("FAIL fill after invalidates: valid=%b word=%h expected 1/%h", instruction_valid, instruction_word, m_conv(fill_words[0]));
        end
        $display("invalidate during refill done");
    endtask

    task automatic test_mode_sum();
        logic [63:0] a = 64'h9100;
        current_mode = 2'd0; current_sum = 1'b0; mmu_enabled = 1'b1;
        rand_words(); do_fetch(a, 0);
        current_mode = 2'd1; current_sum = 1'b1;
        do_fetch(a, 1);
        current_mode = 2'd3; current_sum = 1'b1;
        rand_words(); do_fetch(a, 0);
        current_mode = 2'd1; current_sum = 1'b0;
        rand_words(); do_fetch(a, 0);
        current_mode = 2'd1; current_sum = 1'b0; mmu_enabled = 1'b0;
        rand_words(); do_fetch(a, 0);
        current_mode = 2'd3; current_sum = 1'b0; mmu_enabled = 1'b0;
    endtask

    task automatic test_misaligned();
        do_fetch(64'hB002, 1);
        tick();
        n_checks++;
        if (refill_req !== 1'b0 || instruction_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL misaligned no refill: req=%b valid=%b expected 0/1", refill_req, instruction_valid);
        end
    endtask

    task automatic test_stall_redirect();
        logic [63:0] x = 64'hC0E0;
        logic [63:0] z = 64'hD120;
        redirect = 1'b1; redirect_vaddr = x[63:1]; predicted_vaddr = x[63:1];
        tick();
        redirect = 1'b0; stall = 1'b1;
        tick();
        n_checks++;
        if (refill_req !== 1'b0) begin
            n_fail++;
            $display("FAIL stalled miss: req got %b expected 0", refill_req);
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if (refill_req !== 1'b1 || refill_addr !== x[38:5]) begin
            n_fail++;
            $display("FAIL post-stall refill: req=%b addr=%h expected 1/%h", refill_req, refill_addr, x[38:5]);
        end
        stall = 1'b1; redirect = 1'b1; redirect_vaddr = z[63:1]; predicted_vaddr = z[63:1];
        tick();
        n_checks++;
        if (instruction_vaddr !== x[63:1]) begin
            n_fail++;
            $display("FAIL stall hold: vaddr got %h expected %h", instruction_vaddr, x[63:1]);
        end
        stall = 1'b0;
        tick();
        redirect = 1'b0;
        n_checks++;
        if (instruction_vaddr !== z[63:1] || refill_req !== 1'b1) begin
            n_fail++;
            $display("FAIL redirect in refill: vaddr=%h req=%b expected %h/1", instruction_vaddr, refill_req, z[63:1]);
        end
        stall = 1'b1;
        rand_words();
        refill_valid = 1'b1; refill_data = pack_line();
        m_install(x);
        tick();
        refill_valid = 1'b0;
        n_checks++;
        if (refill_req !== 1'b0 || instruction_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stalled fill: req=%b valid=%b expected 0/0", refill_req, instruction_valid);
        end
        stall = 1'b0;
        do_fetch(x, 1);
    endtask

    task automatic test_reset_mid_refill();
        logic [63:0] w = 64'hE140;
        redirect = 1'b1; redirect_vaddr = w[63:1]; predicted_vaddr = w[63:1];
        tick();
        redirect = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        n_checks++;
        if (refill_req !== 1'b0 || instruction_vaddr !== 63'h0) begin
            n_fail++;
            $display("FAIL reset mid refill: req=%b vaddr=%h expected 0/0", refill_req, instruction_vaddr);
        end
        reset_n = 1'b1; stall = 1'b1;
        m_reset();
        tick();
        rand_words();
        refill_valid = 1'b1; refill_data = pack_line();
        tick();
        refill_valid = 1'b0;
        n_checks++;
        if (instruction_valid !== 1'b0 || refill_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle refill_valid: valid=%b req=%b expected 0/0", instruction_valid, refill_req);
        end
        stall = 1'b0;
        rand_words(); do_fetch(w, 0);
    endtask

    task automatic test_random();
        int t;
        int s;
        int r;
        logic signed [63:0] base;
        logic [63:0] a;
        for (int it = 0; it < 80; it++) begin
            t = $urandom_range(0, 5);
            s = 12 + $urandom_range(0, 1);
            base = (t < 3) ? 64'(t) : -64'(t - 2);
            a = (base << 12) | 64'(s << 5) | 64'($urandom_range(0, 7) << 2);
            if ($urandom_range(0, 9) == 0) a[1] = 1'b1;
            r = $urandom_range(0, 2);
            current_mode = (r == 2) ? 2'd3 : 2'(r);
            current_sum = 1'($urandom_range(0, 1));
            mmu_enabled = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) inv_pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            rand_words();
            do_fetch(a, -1);
        end
    endtask

    initial begin
        test_reset();
        test_compressed();
        test_rr_evict();
        test_selective();
        test_inv_refill();
        test_mode_sum();
        test_misaligned();
        test_stall_redirect();
        test_reset_mid_refill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
